youwin_banner_ctrl: RTL and testbench
=====================================

# youwin_banner_ctrl

Upstream driver and pixel consumer for the 32×32 "you win" sprite ROM: it turns the VGA scan position into ROM read requests, pipelines the ROM's registered 8-bit pixel, and produces a keyed overlay colour for the final colour mux.

- The banner is sprite IDs 0–7 laid left to right, each scaled by 2^SCALE_SHIFT.
- A frame-synchronous state machine controls appearance: blinking after a win, then solid until cleared.

## Interface
Parameters:
- X0, 64: banner left edge, screen pixels.
- Y0, 208: banner top edge, screen pixels.
- SCALE_SHIFT, 1: integer scale factor is 2^SCALE_SHIFT (0–2 supported).
- BLINK_FRAMES, 15: frames per blink half-period (≥1).
- BLINK_TOGGLES, 8: visibility toggles before going solid (even, ≥2).
- TRANSPARENT, 8'h00: pixel value treated as see-through.

Ports:
- CLOCK_50, in, 1: sole clock; all logic on the rising edge.
- RESET, in, 1: asynchronous, active-low reset.
- WIN, in, 1: level or pulse from game logic requesting the banner.
- CLEAR, in, 1: returns the block to IDLE.
- VS, in, 1: one-cycle frame-start pulse during vertical blanking.
- DrawX, in, 10: current scan column.
- DrawY, in, 10: current scan row.
- SPRITE_PIXEL, in, 8: ROM data, valid 1 cycle after the request.
- R_Y_W, out, 1: ROM read enable.
- SPRITE_ID, out, 3: ROM sprite index.
- SPRITE_X, out, 5: ROM pixel column.
- SPRITE_Y, out, 5: ROM pixel row.
- BANNER_ON, out, 1: overlay pixel is opaque this cycle.
- BANNER_COLOR, out, 8: overlay colour, 0 when BANNER_ON=0.
- ACTIVE, out, 1: state ≠ IDLE.

## Operation
Window and address mapping:
- Banner width W = 256<<SCALE_SHIFT; height H = 32<<SCALE_SHIFT.
- in_win = (X0 ≤ DrawX < X0+W) && (Y0 ≤ DrawY < Y0+H).
- dx = DrawX−X0 and dy = DrawY−Y0, both 10-bit unsigned.
- SPRITE_ID = (dx>>(5+SCALE_SHIFT))[2:0].
- SPRITE_X = (dx>>SCALE_SHIFT)[4:0].
- SPRITE_Y = (dy>>SCALE_SHIFT)[4:0].
- Outside the window, SPRITE_ID/X/Y are 0 and R_Y_W=0.
- R_Y_W = in_win && vis.

Visibility: vis = (state==SOLID) || (state==BLINK && phase).

State machine (IDLE, BLINK, SOLID):
- Pending flag: set by WIN while in IDLE; cleared by CLEAR or when consumed.
- IDLE → BLINK at the VS pulse when pending=1. Entry sets phase=1, frame_cnt=0, tog_cnt=0, and clears pending.
- In BLINK, each VS increments frame_cnt. When frame_cnt==BLINK_FRAMES−1: frame_cnt←0, phase toggles, tog_cnt increments.
- When tog_cnt reaches BLINK_TOGGLES, the block goes to SOLID with phase=1. An even BLINK_TOGGLES means the banner ends visible.
- SOLID holds until CLEAR.
- CLEAR, from any state and in any cycle, goes to IDLE and clears pending and all counters. CLEAR wins over a simultaneous WIN or VS.
- WIN outside IDLE is ignored.
- State only changes on VS (or immediately on CLEAR), so the visible banner never tears mid-frame.

Output keying:
- BANNER_ON = vis_d2 && in_win_d2 && SPRITE_PIXEL≠TRANSPARENT.
- BANNER_COLOR = SPRITE_PIXEL when BANNER_ON, else 0.

## Timing
Pipeline, with DrawX/DrawY sampled at cycle n:
- n+1: SPRITE_ID/X/Y and R_Y_W are registered outputs.
- n+2: the ROM presents SPRITE_PIXEL.
- n+3: BANNER_ON and BANNER_COLOR are registered.
- in_win and vis are delayed 2 cycles alongside the data (in_win_d2, vis_d2).

Total latency from DrawX to colour is 3 cycles; the colour mux compensates.

Reset state:
- state=IDLE, pending=0, phase=0, counters=0.
- All outputs 0.
- The pipeline flushes: BANNER_ON=0 for at least 3 cycles after RESET deasserts.

Reset mid-operation: reset asserted during BLINK or SOLID forces IDLE immediately (asynchronously) with all outputs 0.

Throughput: one pixel per clock, no stalls.

## Test plan
- Reset check: assert RESET=0 mid-BLINK. Required: all outputs 0 immediately; ACTIVE=0 after release; no banner until a new WIN plus VS.
- Address mapping: SCALE_SHIFT=1, state SOLID, DrawX=138, DrawY=227. Required at n+1: R_Y_W=1, SPRITE_ID=1, SPRITE_X=5, SPRITE_Y=9. With DrawX=63 or DrawX=576: R_Y_W=0 and address 0.
- Keying and latency: ROM returns 8'h3C for a request issued at n. Required: BANNER_ON=1 and BANNER_COLOR=8'h3C at n+3. ROM returns 8'h00: BANNER_ON=0 and BANNER_COLOR=0.
- Blink sequence: pulse WIN, then issue VS pulses. Required:
  - BLINK starts at the first VS.
  - phase toggles after every 15 further VS.
  - SOLID is entered after 8 toggles (120 VS).
  - vis=1 throughout SOLID.
- Same-cycle conflict: WIN and CLEAR asserted in the same cycle in IDLE, then VS. Required: the block stays IDLE and ACTIVE=0.
- WIN ignored outside IDLE: pulse WIN during SOLID. Required: no state change. Then CLEAR. Required: IDLE next cycle and R_Y_W=0 everywhere.

Source files
------------

// File: rtl/youwin_banner_ctrl_if.sv
// Read port between the banner controller and the 32x32 "you win" sprite ROM.
// The ROM registers its pixel, so SPRITE_PIXEL answers the request of the previous cycle.
interface youwin_banner_ctrl_if;
  logic       R_Y_W;
  logic [2:0] SPRITE_ID;
  logic [4:0] SPRITE_X;
  logic [4:0] SPRITE_Y;
  logic [7:0] SPRITE_PIXEL;

  modport master (
    output R_Y_W, SPRITE_ID, SPRITE_X, SPRITE_Y,
    input  SPRITE_PIXEL
  );

  modport slave (
    input  R_Y_W, SPRITE_ID, SPRITE_X, SPRITE_Y,
    output SPRITE_PIXEL
  );
endinterface

// File: rtl/youwin_banner_ctrl.sv
// Maps the VGA scan position onto sprite ROM reads and keys the returned pixel into
// a banner overlay colour; a frame-synchronous FSM blinks the banner after a win.
module youwin_banner_ctrl #(
  parameter int unsigned X0            = 64,
  parameter int unsigned Y0            = 208,
  parameter int unsigned SCALE_SHIFT   = 1,
  parameter int unsigned BLINK_FRAMES  = 15,
  parameter int unsigned BLINK_TOGGLES = 8,
  parameter logic [7:0]  TRANSPARENT   = 8'h00
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET,
  input  logic                        WIN,
  input  logic                        CLEAR,
  input  logic                        VS,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  youwin_banner_ctrl_if.master        rom,
  output logic                        BANNER_ON,
  output logic [7:0]                  BANNER_COLOR,
  output logic                        ACTIVE
);

  localparam int unsigned W  = 256 << SCALE_SHIFT;
  localparam int unsigned H  = 32 << SCALE_SHIFT;
  localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned TW = $clog2(BLINK_TOGGLES + 1);
  localparam logic [9:0]    X0_10      = X0[9:0];
  localparam logic [9:0]    Y0_10      = Y0[9:0];
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [TW-1:0] TOG_LAST   = TW'(BLINK_TOGGLES - 1);

  typedef enum logic [1:0] {IDLE, BLINK, SOLID} state_e;

  state_e        state_q, state_d;
  logic          pending_q, pending_d;
  logic          phase_q, phase_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [TW-1:0] tog_q, tog_d;

  logic          vis;
  logic          in_win;
  logic [31:0]   x_w, y_w;
  logic [9:0]    dx, dy, id_full, sx_full, sy_full;

  logic          rd_q, rd_d;
  logic [2:0]    id_q, id_d;
  logic [4:0]    sx_q, sx_d;
  logic [4:0]    sy_q, sy_d;
  logic          in_win_d1_q, vis_d1_q, in_win_d2_q, vis_d2_q;
  logic          on_q, on_d;
  logic [7:0]    color_q, color_d;

  // ---------------- frame-synchronous appearance FSM ----------------
  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      phase_q   <= 1'b0;
      frame_q   <= '0;
      tog_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      phase_q   <= phase_d;
      frame_q   <= frame_d;
      tog_q     <= tog_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    phase_d   = phase_q;
    frame_d   = frame_q;
    tog_d     = tog_q;
    if (CLEAR) begin
      state_d   = IDLE;
      pending_d = 1'b0;
      phase_d   = 1'b0;
      frame_d   = '0;
      tog_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (WIN) pending_d = 1'b1;
          if (VS && pending_q) begin
            state_d   = BLINK;
            pending_d = 1'b0;
            phase_d   = 1'b1;
            frame_d   = '0;
            tog_d     = '0;
          end
        end
        BLINK: begin
          if (VS) begin
            if (frame_q == FRAME_LAST) begin
              frame_d = '0;
              phase_d = ~phase_q;
              tog_d   = tog_q + TW'(1);
              // The last toggle lands on the same VS that hands over to SOLID.
              if (tog_q == TOG_LAST) begin
                state_d = SOLID;
                phase_d = 1'b1;
              end
            end else begin
              frame_d = frame_q + FW'(1);
            end
          end
        end
        SOLID: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign vis    = (state_q == SOLID) || ((state_q == BLINK) && phase_q);
  assign ACTIVE = (state_q != IDLE);

  // ---------------- window and ROM address mapping ----------------
  assign x_w     = {22'd0, DrawX};
  assign y_w     = {22'd0, DrawY};
  assign in_win  = (x_w >= X0) && (x_w < X0 + W) && (y_w >= Y0) && (y_w < Y0 + H);
  assign dx      = DrawX - X0_10;
  assign dy      = DrawY - Y0_10;
  assign id_full = dx >> (5 + SCALE_SHIFT);
  assign sx_full = dx >> SCALE_SHIFT;
  assign sy_full = dy >> SCALE_SHIFT;

  always_comb begin
    rd_d = in_win && vis;
    id_d = '0;
    sx_d = '0;
    sy_d = '0;
    if (in_win) begin
      id_d = id_full[2:0];
      sx_d = sx_full[4:0];
      sy_d = sy_full[4:0];
    end
  end

  // in_win/vis ride two stages so they meet the ROM pixel of the same request.
  always_comb begin
    on_d    = vis_d2_q && in_win_d2_q && (rom.SPRITE_PIXEL != TRANSPARENT);
    color_d = on_d ? rom.SPRITE_PIXEL : '0;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      rd_q        <= 1'b0;
      id_q        <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      in_win_d1_q <= 1'b0;
      vis_d1_q    <= 1'b0;
      in_win_d2_q <= 1'b0;
      vis_d2_q    <= 1'b0;
      on_q        <= 1'b0;
      color_q     <= '0;
    end else begin
      rd_q        <= rd_d;
      id_q        <= id_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      in_win_d1_q <= in_win;
      vis_d1_q    <= vis;
      in_win_d2_q <= in_win_d1_q;
      vis_d2_q    <= vis_d1_q;
      on_q        <= on_d;
      color_q     <= color_d;
    end
  end

  assign rom.R_Y_W     = rd_q;
  assign rom.SPRITE_ID = id_q;
  assign rom.SPRITE_X  = sx_q;
  assign rom.SPRITE_Y  = sy_q;
  assign BANNER_ON     = on_q;
  assign BANNER_COLOR  = color_q;

endmodule

// File: tb/tb_youwin_banner_ctrl.sv
// Scoreboard bench for youwin_banner_ctrl: stimulus queues expected values with a
// due cycle, a monitor on the falling edge pops and compares them.
module tb_youwin_banner_ctrl;

  logic       clk = 1'b0;
  logic       RESET = 1'b0;
  logic       WIN = 1'b0, CLEAR = 1'b0, VS = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic       BANNER_ON, ACTIVE;
  logic [7:0] BANNER_COLOR;

  youwin_banner_ctrl_if bus();

  youwin_banner_ctrl #(
    .X0(64), .Y0(208), .SCALE_SHIFT(1), .BLINK_FRAMES(15),
    .BLINK_TOGGLES(8), .TRANSPARENT(8'h00)
  ) dut (
    .CLOCK_50(clk), .RESET(RESET), .WIN(WIN), .CLEAR(CLEAR), .VS(VS),
    .DrawX(DrawX), .DrawY(DrawY), .rom(bus.master),
    .BANNER_ON(BANNER_ON), .BANNER_COLOR(BANNER_COLOR), .ACTIVE(ACTIVE)
  );

  always #5 clk = ~clk;

  // Registered ROM model: pixel = {id, x}; unrequested reads return junk (FF).
  always @(posedge clk) bus.SPRITE_PIXEL <= bus.R_Y_W ? {bus.SPRITE_ID, bus.SPRITE_X} : 8'hFF;

  localparam int S_ACT = 0, S_RD = 1, S_ID = 2, S_SX = 3, S_SY = 4, S_ON = 5, S_COL = 6;

  typedef struct {
    int         due;
    int         sel;
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sample(input int sel);
    case (sel)
      S_ACT:   return {7'd0, ACTIVE};
      S_RD:    return {7'd0, bus.R_Y_W};
      S_ID:    return {5'd0, bus.SPRITE_ID};
      S_SX:    return {3'd0, bus.SPRITE_X};
      S_SY:    return {3'd0, bus.SPRITE_Y};
      S_ON:    return {7'd0, BANNER_ON};
      default: return BANNER_COLOR;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    int i;
    logic [7:0] got;
    i = 0;
    while (i < q.size()) begin
      if (q[i].due <= cyc) begin
        got = sample(q[i].sel);
        n_checks++;
        if (q[i].due < cyc) begin
          n_fail++;
          $display("FAIL %s: check missed its cycle (due %0d, now %0d)", q[i].name, q[i].due, cyc);
        end else if (got !== q[i].exp) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %h, expected %h", q[i].name, cyc, got, q[i].exp);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic expect_at(input int sel, input logic [7:0] exp, input int lat, input string name);
    chk_t c;
    c.due = cyc + lat;
    c.sel = sel;
    c.exp = exp;
    c.name = name;
    q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_in(input logic win, input logic clr, input logic vs);
    tick();
    WIN = win;
    CLEAR = clr;
    VS = vs;
  endtask

  // One VS pulse; then check ACTIVE now and R_Y_W for the post-VS state next cycle.
  task automatic vs_pulse(input logic exp_act, input logic exp_rd, input string name);
    cyc_in(1'b0, 1'b0, 1'b1);
    cyc_in(1'b0, 1'b0, 1'b0);
    expect_at(S_ACT, {7'd0, exp_act}, 0, {name, "_active"});
    expect_at(S_RD, {7'd0, exp_rd}, 1, {name, "_rd"});
  endtask

  typedef struct {
    logic [9:0] x, y;
    logic       rd;
    logic [2:0] id;
    logic [4:0] sx, sy;
    logic       on;
    logic [7:0] col;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit exp_vis;
    int wait_cyc;

    // x, y, R_Y_W, ID, X, Y, BANNER_ON, COLOR (ROM pixel = {id,x})
    vecs[0] = '{10'd138, 10'd227, 1'b1, 3'd1, 5'd5,  5'd9,  1'b1, 8'h25};
    vecs[1] = '{10'd63,  10'd227, 1'b0, 3'd0, 5'd0,  5'd0,  1'b0, 8'h00};
    vecs[2] = '{10'd576, 10'd227, 1'b0, 3'd0, 5'd0,  5'd0,  1'b0, 8'h00};
    vecs[3] = '{10'd575, 10'd271, 1'b1, 3'd7, 5'd31, 5'd31, 1'b1, 8'hFF};
    vecs[4] = '{10'd64,  10'd208, 1'b1, 3'd0, 5'd0,  5'd0,  1'b0, 8'h00};
    vecs[5] = '{10'd184, 10'd208, 1'b1, 3'd1, 5'd28, 5'd0,  1'b1, 8'h3C};
    vecs[6] = '{10'd184, 10'd272, 1'b0, 3'd0, 5'd0,  5'd0,  1'b0, 8'h00};
    vecs[7] = '{10'd184, 10'd207, 1'b0, 3'd0, 5'd0,  5'd0,  1'b0, 8'h00};

    // Reset state
    tick();
    expect_at(S_ACT, 8'd0, 0, "rst_active");
    expect_at(S_RD,  8'd0, 0, "rst_rd");
    expect_at(S_ON,  8'd0, 0, "rst_on");
    expect_at(S_COL, 8'd0, 0, "rst_color");
    tick();
    DrawX = 10'd138;
    DrawY = 10'd227;
    tick();
    RESET = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_at(S_ON, 8'd0, 0, "flush_on");
      expect_at(S_ACT, 8'd0, 0, "flush_active");
      tick();
    end

    // WIN and CLEAR together in IDLE: CLEAR wins, VS must not start the banner
    cyc_in(1'b1, 1'b1, 1'b0);
    vs_pulse(1'b0, 1'b0, "winclr_vs");
    vs_pulse(1'b0, 1'b0, "winclr_vs2");

    // Blink sequence: entry VS is k=0, SOLID after 120 further VS
    cyc_in(1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 124; k++) begin
      exp_vis = (k >= 120) ? 1'b1 : (((k / 15) % 2) == 0);
      vs_pulse(1'b1, exp_vis, $sformatf("blink_k%0d", k));
    end

    // Address mapping and keying in SOLID, one new position per clock
    for (int v = 0; v < 8; v++) begin
      tick();
      DrawX = vecs[v].x;
      DrawY = vecs[v].y;
      expect_at(S_RD,  {7'd0, vecs[v].rd}, 1, $sformatf("map%0d_rd", v));
      expect_at(S_ID,  {5'd0, vecs[v].id}, 1, $sformatf("map%0d_id", v));
      expect_at(S_SX,  {3'd0, vecs[v].sx}, 1, $sformatf("map%0d_x", v));
      expect_at(S_SY,  {3'd0, vecs[v].sy}, 1, $sformatf("map%0d_y", v));
      expect_at(S_ON,  {7'd0, vecs[v].on}, 3, $sformatf("key%0d_on", v));
      expect_at(S_COL, vecs[v].col,        3, $sformatf("key%0d_color", v));
    end
    tick();
    DrawX = 10'd138;
    DrawY = 10'd227;
    tick();

    // WIN in SOLID is ignored
    cyc_in(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) vs_pulse(1'b1, 1'b1, "solid_win");

    // CLEAR returns to IDLE the next cycle; no reads anywhere afterwards
    cyc_in(1'b0, 1'b1, 1'b0);
    expect_at(S_ACT, 8'd0, 1, "clear_active");
    expect_at(S_RD,  8'd0, 2, "clear_rd");
    cyc_in(1'b0, 1'b0, 1'b0);
    for (int v = 0; v < 8; v++) begin
      tick();
      DrawX = vecs[v].x;
      DrawY = vecs[v].y;
      expect_at(S_RD, 8'd0, 1, "cleared_rd");
    end
    vs_pulse(1'b0, 1'b0, "cleared_vs");
    tick();
    DrawX = 10'd138;
    DrawY = 10'd227;

    // Reset asserted mid-BLINK
    cyc_in(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) vs_pulse(1'b1, 1'b1, "pre_rst");
    tick();
    tick();
    expect_at(S_ON,  8'd1,  0, "pre_rst_on");
    expect_at(S_COL, 8'h25, 0, "pre_rst_color");
    tick();
    RESET = 1'b0;
    expect_at(S_ACT, 8'd0, 0, "midrst_active");
    expect_at(S_RD,  8'd0, 0, "midrst_rd");
    expect_at(S_ID,  8'd0, 0, "midrst_id");
    expect_at(S_SX,  8'd0, 0, "midrst_x");
    expect_at(S_SY,  8'd0, 0, "midrst_y");
    expect_at(S_ON,  8'd0, 0, "midrst_on");
    expect_at(S_COL, 8'd0, 0, "midrst_color");
    tick();
    tick();
    RESET = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_at(S_ACT, 8'd0, 0, "postrst_active");
      expect_at(S_ON,  8'd0, 0, "postrst_on");
      tick();
    end
    for (int k = 0; k < 3; k++) vs_pulse(1'b0, 1'b0, "postrst_vs");

    wait_cyc = 0;
    while (q.size() != 0 && wait_cyc < 50) begin
      tick();
      wait_cyc++;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d checks still pending, expected 0", q.size());
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
